// File: rtl/pattern_sweep_capture.sv
// Purpose: sweeps a stimulus vector (binary count or LFSR) and compacts the 1-bit response into a count and a signature.
// Latency: each vector is held SETTLE cycles and sampled on the next; done pulses N*(SETTLE+1)+1 cycles after start.
// Backpressure: none; start is ignored while a run is active and abort ends a run early without done.
module pattern_sweep_capture #(
    parameter int VEC_W  = 7,
    parameter int SETTLE = 2,
    parameter int SIG_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             resp_in,
    output logic [VEC_W-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic [7:0]       ones_cnt,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state;
    logic [3:0]       settle_cnt;
    logic             mode_q;
    logic [VEC_W-1:0] lfsr_next;
    logic [VEC_W-1:0] vec_next;
    logic             vec_last;
    logic             fb;

    always_comb begin
        lfsr_next = {vec_out[VEC_W-2:0], vec_out[VEC_W-1] ^ vec_out[VEC_W-2]};
        vec_next  = mode_q ? lfsr_next : vec_out + VEC_W'(1);
        // The LFSR run ends on the vector that would wrap back to the seed.
        vec_last  = mode_q ? (lfsr_next == VEC_W'(1)) : (&vec_out);
        fb        = signature[15] ^ signature[14] ^ signature[12] ^ signature[3] ^ resp_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones_cnt   <= '0;
            signature  <= '0;
            settle_cnt <= '0;
            mode_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        mode_q     <= mode;
                        ones_cnt   <= '0;
                        signature  <= '0;
                        vec_out    <= mode ? VEC_W'(1) : '0;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        vec_out    <= '0;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    // Abort wins over the sample: the partial results exclude this vector.
                    if (abort) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        vec_out    <= '0;
                        settle_cnt <= '0;
                    end else begin
                        ones_cnt  <= ones_cnt + 8'(resp_in);
                        signature <= {signature[SIG_W-2:0], fb};
                        if (vec_last) begin
                            state <= S_DONE;
                        end else begin
                            vec_out <= vec_next;
                            state   <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pattern_sweep_capture.md
PATTERN_SWEEP_CAPTURE -- requirements
Module: pattern_sweep_capture

Interface
REQ-001 Parameter VEC_W, default 7: width of the stimulus vector driven to the combinational stage.
REQ-002 Parameter SETTLE, default 2, legal 1..15: cycles each vector is held before the response is sampled.
REQ-003 Parameter SIG_W, default 16: width of the response signature register.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 mode  input  1  sampled with accepted start: 0 = exhaustive count, 1 = LFSR sequence.
REQ-008 abort  input  1  terminate a run immediately without done.
REQ-009 resp_in  input  1  single-bit response from the combinational stage.
REQ-010 vec_out  output  VEC_W  stimulus vector to the combinational stage, registered.
REQ-011 busy  output  1  high from the cycle after an accepted start until the run ends.
REQ-012 done  output  1  one-cycle pulse at normal run completion.
REQ-013 ones_cnt  output  8  count of sampled responses equal to 1.
REQ-014 signature  output  SIG_W  serial response signature.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DONE; encoding is implementation choice.
REQ-016 IDLE: start=1 -> SETTLE; mode latched; ones_cnt and signature cleared; vec_out loaded with first vector; busy=1 next cycle.
REQ-017 Start while busy is ignored; mode changes during a run are ignored.
REQ-018 First vector: 0 in exhaustive mode, 7'h01 in LFSR mode.
REQ-019 SETTLE: vec_out held; internal counter runs SETTLE cycles, then -> SAMPLE.
REQ-020 SAMPLE (one cycle): resp_in sampled; ones_cnt += resp_in; signature updated per REQ-022.
REQ-021 SAMPLE exit: last vector -> DONE, vec_out held; otherwise vec_out advanced -> SETTLE.
REQ-022 Signature update: signature <= {signature[SIG_W-2:0], fb}, fb = signature[15]^signature[14]^signature[12]^signature[3]^resp_in (polynomial x^16+x^15+x^13+x^4+1).
REQ-023 Exhaustive advance: vec_out+1; last vector 127; 128 vectors per run.
REQ-024 LFSR advance: vec_out <= {vec_out[5:0], vec_out[6]^vec_out[5]}; last vector is the one whose successor equals 7'h01; 127 vectors, never 0.
REQ-025 Per-vector cost SETTLE+1 cycles; done asserts exactly N*(SETTLE+1)+1 cycles after the accepted start edge (N = 128 or 127).
REQ-026 DONE (one cycle): done=1, busy=0; -> IDLE. ones_cnt, signature and vec_out hold until the next accepted start.
REQ-027 ones_cnt is 8 bits and cannot overflow (max 128).
REQ-028 abort=1 in SETTLE or SAMPLE: -> IDLE next edge; busy=0; done stays 0; vec_out=0; ones_cnt/signature hold partial values; no sample taken in that cycle.
REQ-029 abort has priority over SAMPLE completion; abort in IDLE or DONE has no effect.

Reset
REQ-030 rst_n=0 at a clock edge: state=IDLE, vec_out=0, busy=0, done=0, ones_cnt=0, signature=0, counters=0, mode latch=0.
REQ-031 Reset overrides start and abort; reset mid-run discards the run with no done pulse.
REQ-032 No output changes without a clock edge, including on the reset itself.

Verification
REQ-033 mode=0, SETTLE=2, resp_in=1 constant, start pulse -> vec_out steps 0..127, each held 3 cycles; done at cycle 385 after start; ones_cnt=128.
REQ-034 mode=1, resp_in=0 constant -> vec_out sequence 01,02,04,08,10,20,41,03,...; 127 distinct non-zero vectors; ones_cnt=0, signature=0.
REQ-035 mode=0, resp_in = vec_out[0] via a bench model -> ones_cnt=64; signature matches reference model bit-exact.
REQ-036 start re-pulsed at vector 10 -> ignored; run completes unchanged; single done pulse.
REQ-037 abort in SAMPLE at vector 5 -> next cycle busy=0, vec_out=0, done never asserts, ones_cnt reflects vectors 0..4 only.
REQ-038 rst_n=0 for one cycle mid-run -> all outputs zero next edge; a new start then runs a full clean sweep.
